pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core; drives enable and synchronous-clear of PC, IF/ID, ID/EX, EX/MEM, MEM/WB latches.
- Combines load-use hazard detection, branch flush and debug run/step/halt control.
- Handles end-of-program drain: fetch stops when eop reaches EX, then the pipe empties before halting.

Parameters:
- DRAIN_CYCLES, 3, advancing cycles after eop seen in EX before halt (EX->MEM->WB->commit).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  system clock; state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- run_cmd  in  1  one-cycle pulse: enter continuous run.
- step_cmd  in  1  one-cycle pulse: advance pipeline exactly one cycle.
- halt_cmd  in  1  one-cycle pulse: freeze pipeline.
- id_rs  in  5  rs of instruction in ID.
- id_rt  in  5  rt of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as source.
- branch_taken  in  1  branch/jump resolved taken in ID.
- ex_mem_to_reg  in  1  memToReg of instruction in EX (load).
- ex_rt  in  5  rt of instruction in EX.
- ex_eop  in  1  eop flag of instruction in EX.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID enable.
- ifid_clr  out  1  IF/ID sync clear (bubble).
- idex_en  out  1  ID/EX enable.
- idex_clr  out  1  ID/EX sync clear (bubble).
- back_en  out  1  EX/MEM and MEM/WB enable.
- state  out  2  FSM state: IDLE=0, RUN=1, STEP=2, DRAIN=3.
- halted  out  1  program finished.
- cycle_cnt  out  CNT_W  advancing cycles.
- stall_cnt  out  CNT_W  load-use stall cycles.

Behaviour:
- Reset: state=IDLE, halted=0, drain counter=0, counters=0; all enables/clears 0.
- adv = (state != IDLE). All outputs except state/halted/counters are combinational from adv, state and current hazard inputs (zero latency).
- load_use = ex_mem_to_reg & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- adv=0: every enable and clear 0 (full freeze).
- adv=1, load_use=1: pc_en=0, ifid_en=0, idex_en=1, idex_clr=1, back_en=1. load_use beats branch_taken.
- adv=1, branch_taken=1, load_use=0: all enables 1, ifid_clr=1.
- adv=1, otherwise: all enables 1, clears 0.
- DRAIN overrides fetch: pc_en=0, ifid_en=1, ifid_clr=1. load_use still stalls ID as above.
- IDLE transitions:
  - run_cmd & !halted -> RUN.
  - step_cmd & !halted -> STEP.
  - Both asserted: run_cmd wins.
  - halted=1: commands ignored until reset.
- RUN transitions:
  - halt_cmd -> IDLE; beats ex_eop.
  - ex_eop & !load_use -> DRAIN, drain counter = DRAIN_CYCLES-1.
- STEP: one cycle only. ex_eop -> DRAIN; otherwise -> IDLE.
- DRAIN: counter decrements each cycle; at 0 -> IDLE with halted=1. halt_cmd, run_cmd and step_cmd are ignored.
- Counters:
  - cycle_cnt +1 per adv cycle.
  - stall_cnt +1 per adv & load_use cycle.
  - Both saturate at all-ones.
- Reset mid-DRAIN or mid-RUN: immediate return to reset values.

Optional Feature:
- PIPE_PERF_CNT_EN defined: cycle_cnt and stall_cnt implemented as above.
- Undefined: no counter registers; both outputs tied to 0.

Decomposition:
- Shared package pipe_ctrl_pkg: state encodings (ST_IDLE, ST_RUN, ST_STEP, ST_DRAIN), REG_ZERO=5'd0, control-vector field widths.
- One sub-module: load_use_detect (pure combinational load_use equation), reusable by the forwarding unit.

Test Plan:
- Reset, then run_cmd; no hazards for 10 cycles -> all enables 1, cycle_cnt=10, stall_cnt=0.
- RUN, ex_mem_to_reg=1, ex_rt=5, id_rs=5 -> one cycle pc_en=0, ifid_en=0, idex_clr=1; stall_cnt=1. With ex_rt=0 -> no stall.
- RUN, branch_taken=1 together with load_use=1 -> only the stall pattern (ifid_clr=0). Next cycle, load_use=0 and branch_taken=1 -> ifid_clr=1.
- IDLE, step_cmd pulse -> exactly one cycle with enables=1, then state=IDLE. Frozen 5 cycles: enables 0, cycle_cnt unchanged.
- RUN, ex_eop=1 -> DRAIN for 3 cycles with pc_en=0 and ifid_clr=1, then IDLE with halted=1. run_cmd afterwards is ignored; reset clears halted.
- RUN, halt_cmd and ex_eop in the same cycle -> IDLE, halted=0. Reset during DRAIN -> state=0, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and its helpers:
// FSM state encodings, the zero-register index and the control-vector layout.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int STATE_W    = 2;
    localparam int CTRL_W     = 6;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } pipe_state_e;

    // Enable/clear bundle for the PC and the four pipeline latches.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_clr;
        logic idex_en;
        logic idex_clr;
        logic back_en;
    } ctrl_vec_t;

    // Pipeline fully frozen: nothing loads, nothing clears.
    function automatic ctrl_vec_t ctrl_freeze();
        ctrl_vec_t c;
        c = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0,
              idex_en: 1'b0, idex_clr: 1'b0, back_en: 1'b0};
        return c;
    endfunction

    // Normal advance: every latch loads, no bubbles.
    function automatic ctrl_vec_t ctrl_flow();
        ctrl_vec_t c;
        c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b0,
              idex_en: 1'b1, idex_clr: 1'b0, back_en: 1'b1};
        return c;
    endfunction

    // Load-use stall: hold PC and IF/ID, inject a bubble into ID/EX.
    function automatic ctrl_vec_t ctrl_stall();
        ctrl_vec_t c;
        c = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_clr: 1'b0,
              idex_en: 1'b1, idex_clr: 1'b1, back_en: 1'b1};
        c.ifid_en = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that sources the
// destination of a load currently in EX. Pure combinational so the
// forwarding unit can reuse it.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  ex_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    output logic                  load_use
);

    logic rs_hit_s;
    logic rt_hit_s;

    // Compare the load destination against both ID sources; $zero never hazards.
    always_comb begin
        rs_hit_s = (ex_rt == id_rs);
        rt_hit_s = id_uses_rt & (ex_rt == id_rt);
        load_use = ex_mem_to_reg & (ex_rt != REG_ZERO) & (rs_hit_s | rt_hit_s);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: combines load-use stalls,
// branch flushes, debug run/step/halt and end-of-program drain into the
// enable/clear controls of the PC and pipeline latches.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined;
// otherwise cycle_cnt and stall_cnt read as zero.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_cmd,
    input  logic                  step_cmd,
    input  logic                  halt_cmd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  branch_taken,
    input  logic                  ex_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_eop,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_clr,
    output logic                  idex_en,
    output logic                  idex_clr,
    output logic                  back_en,
    output logic [STATE_W-1:0]    state,
    output logic                  halted,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(DRAIN_CYCLES - 1);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             halted_q;
    logic             halted_d;
    logic [DRN_W-1:0] drain_q;
    logic [DRN_W-1:0] drain_d;

    logic             load_use_s;
    logic             adv_s;
    ctrl_vec_t        ctrl_s;

    load_use_detect u_load_use_detect (
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_rt         (ex_rt),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .load_use      (load_use_s)
    );

    assign adv_s = (state_q != ST_IDLE);

    // State, halted flag and drain counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
            drain_q  <= {DRN_W{1'b0}};
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            drain_q  <= drain_d;
        end
    end

    // Next-state logic: debug commands, end-of-program detection and drain countdown.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        drain_d  = drain_q;
        case (state_q)
            ST_IDLE: begin
                // Once halted, only reset can restart the pipe.
                if (!halted_q && run_cmd) begin
                    state_d = ST_RUN;
                end else if (!halted_q && step_cmd) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A stalled eop has not really left EX yet, so wait for the stall to clear.
                if (halt_cmd) begin
                    state_d = ST_IDLE;
                end else if (ex_eop && !load_use_s) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                if (ex_eop) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Debug commands are deliberately ignored until the pipe is empty.
                if (drain_q == {DRN_W{1'b0}}) begin
                    state_d  = ST_IDLE;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                    drain_d = drain_q - {{(DRN_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                drain_d = {DRN_W{1'b0}};
            end
        endcase
    end

    // Output decode: zero-latency latch controls; load-use beats both drain and branch flush.
    always_comb begin
        ctrl_s = ctrl_freeze();
        if (!adv_s) begin
            ctrl_s = ctrl_freeze();
        end else if (load_use_s) begin
            ctrl_s = ctrl_stall();
        end else if (state_q == ST_DRAIN) begin
            ctrl_s          = ctrl_flow();
            ctrl_s.pc_en    = 1'b0;
            ctrl_s.ifid_clr = 1'b1;
        end else if (branch_taken) begin
            ctrl_s          = ctrl_flow();
            ctrl_s.ifid_clr = 1'b1;
        end else begin
            ctrl_s = ctrl_flow();
        end
    end

    assign pc_en    = ctrl_s.pc_en;
    assign ifid_en  = ctrl_s.ifid_en;
    assign ifid_clr = ctrl_s.ifid_clr;
    assign idex_en  = ctrl_s.idex_en;
    assign idex_clr = ctrl_s.idex_clr;
    assign back_en  = ctrl_s.back_en;
    assign state    = state_q;
    assign halted   = halted_q;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating increment of the advance and stall counters.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (adv_s && (cycle_cnt_q != CNT_MAX)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
        if (adv_s && load_use_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Performance counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= {CNT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign cycle_cnt = {CNT_W{1'b0}};
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. Expected counter values follow
// the PIPE_PERF_CNT_EN build option (zero when counters are not built).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector order: {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, back_en}
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_FLOW   = 6'b110101;
    localparam logic [5:0] C_STALL  = 6'b000111;
    localparam logic [5:0] C_BRANCH = 6'b111101;
    localparam logic [5:0] C_DRAIN  = 6'b011101;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_cmd, step_cmd, halt_cmd;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, branch_taken, ex_mem_to_reg, ex_eop;
    logic        pc_en, ifid_en, ifid_clr, idex_en, idex_clr, back_en;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] cycle_cnt, stall_cnt;
    logic [5:0]  ctrl;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign ctrl = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, back_en};

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .run_cmd(run_cmd), .step_cmd(step_cmd), .halt_cmd(halt_cmd),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .branch_taken(branch_taken), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_rt(ex_rt), .ex_eop(ex_eop),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
        .idex_en(idex_en), .idex_clr(idex_clr), .back_en(back_en),
        .state(state), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] ecnt(input int n);
        return PERF ? 64'(n) : 64'd0;
    endfunction

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run_cmd = 1'b0; step_cmd = 1'b0; halt_cmd = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0;
        branch_taken = 1'b0; ex_mem_to_reg = 1'b0; ex_eop = 1'b0;
        tick(); tick();
        reset = 1'b0; #1;

        // Reset state
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_ctrl", 64'(ctrl), 64'(C_FREEZE));
        chk("rst_cyc", 64'(cycle_cnt), 64'd0);
        chk("rst_stl", 64'(stall_cnt), 64'd0);

        // Enter RUN; still frozen during the command cycle
        run_cmd = 1'b1; #1;
        chk("idle_ctrl", 64'(ctrl), 64'(C_FREEZE));
        tick(); run_cmd = 1'b0; #1;
        chk("run_state", 64'(state), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("run_flow", 64'(ctrl), 64'(C_FLOW));
            tick();
        end
        chk("run_cyc10", 64'(cycle_cnt), ecnt(10));
        chk("run_stl0", 64'(stall_cnt), ecnt(0));

        // Load-use via rs
        ex_mem_to_reg = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
        chk("lu_rs_ctrl", 64'(ctrl), 64'(C_STALL));
        tick();
        chk("lu_rs_stl", 64'(stall_cnt), ecnt(1));
        // $zero destination never stalls
        ex_rt = 5'd0; id_rs = 5'd0; #1;
        chk("lu_zero_ctrl", 64'(ctrl), 64'(C_FLOW));
        tick();
        // rt match only counts when ID uses rt
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0; #1;
        chk("lu_rt_unused", 64'(ctrl), 64'(C_FLOW));
        id_uses_rt = 1'b1; #1;
        chk("lu_rt_used", 64'(ctrl), 64'(C_STALL));
        tick();
        chk("lu_rt_stl", 64'(stall_cnt), ecnt(2));

        // Branch together with load-use: stall wins, no IF/ID flush
        id_uses_rt = 1'b0; ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1; #1;
        chk("br_lu_ctrl", 64'(ctrl), 64'(C_STALL));
        tick();
        ex_mem_to_reg = 1'b0; #1;
        chk("br_ctrl", 64'(ctrl), 64'(C_BRANCH));
        tick();
        branch_taken = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        chk("br_cyc", 64'(cycle_cnt), ecnt(15));
        chk("br_stl", 64'(stall_cnt), ecnt(3));

        // Halt and eop together: halt wins
        halt_cmd = 1'b1; ex_eop = 1'b1; #1;
        tick();
        halt_cmd = 1'b0; ex_eop = 1'b0; #1;
        chk("halt_state", 64'(state), 64'd0);
        chk("halt_halted", 64'(halted), 64'd0);

        // Frozen for 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk("frz_ctrl", 64'(ctrl), 64'(C_FREEZE));
            tick();
        end
        chk("frz_cyc", 64'(cycle_cnt), ecnt(16));

        // Single step
        step_cmd = 1'b1; tick(); step_cmd = 1'b0; #1;
        chk("step_state", 64'(state), 64'd2);
        chk("step_ctrl", 64'(ctrl), 64'(C_FLOW));
        tick();
        chk("step_back", 64'(state), 64'd0);
        chk("step_frz", 64'(ctrl), 64'(C_FREEZE));
        chk("step_cyc", 64'(cycle_cnt), ecnt(17));

        // run and step together: run wins
        run_cmd = 1'b1; step_cmd = 1'b1; tick();
        run_cmd = 1'b0; step_cmd = 1'b0; #1;
        chk("runstep_state", 64'(state), 64'd1);

        // eop held by a load-use stall stays in RUN
        ex_eop = 1'b1; ex_mem_to_reg = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; #1;
        tick();
        chk("eop_lu_state", 64'(state), 64'd1);
        ex_mem_to_reg = 1'b0; #1;
        tick();
        ex_eop = 1'b0; #1;
        chk("drain_state", 64'(state), 64'd3);

        // Drain: three cycles, commands ignored, load-use still stalls
        halt_cmd = 1'b1; #1;
        chk("drain1_ctrl", 64'(ctrl), 64'(C_DRAIN));
        tick();
        halt_cmd = 1'b0;
        chk("drain2_state", 64'(state), 64'd3);
        ex_mem_to_reg = 1'b1; #1;
        chk("drain2_ctrl", 64'(ctrl), 64'(C_STALL));
        tick();
        ex_mem_to_reg = 1'b0; run_cmd = 1'b1; #1;
        chk("drain3_ctrl", 64'(ctrl), 64'(C_DRAIN));
        tick();
        run_cmd = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; #1;
        chk("end_state", 64'(state), 64'd0);
        chk("end_halted", 64'(halted), 64'd1);
        chk("end_ctrl", 64'(ctrl), 64'(C_FREEZE));

        // run after halt is ignored
        run_cmd = 1'b1; tick(); run_cmd = 1'b0; #1;
        chk("halted_run_state", 64'(state), 64'd0);
        chk("halted_cyc", 64'(cycle_cnt), ecnt(22));
        chk("halted_stl", 64'(stall_cnt), ecnt(5));

        // Reset clears halted and counters
        reset = 1'b1; tick(); reset = 1'b0; #1;
        chk("rst2_halted", 64'(halted), 64'd0);
        chk("rst2_cyc", 64'(cycle_cnt), 64'd0);

        // Step onto eop enters drain; reset mid-drain
        step_cmd = 1'b1; tick(); step_cmd = 1'b0; ex_eop = 1'b1; #1;
        tick();
        ex_eop = 1'b0; #1;
        chk("step_eop_state", 64'(state), 64'd3);
        tick();
        reset = 1'b1; tick(); reset = 1'b0; #1;
        chk("rst_drain_state", 64'(state), 64'd0);
        chk("rst_drain_cyc", 64'(cycle_cnt), 64'd0);
        chk("rst_drain_stl", 64'(stall_cnt), 64'd0);
        chk("rst_drain_ctrl", 64'(ctrl), 64'(C_FREEZE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
